// File: rtl/pic_int_arb.sv
// pic_int_arb: priority arbiter and claim/complete sequencer feeding the core's external interrupt.
// Optional feature: define PIC_ARB_RR_EN for round-robin tie-break among equal top priorities.
module pic_int_arb #(
  parameter int unsigned INT_NUM = 16,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = $clog2(INT_NUM)
) (
  input  logic                      pic_clk,
  input  logic                      pic_rst,
  input  logic [INT_NUM-1:0]        int_pend,
  input  logic [INT_NUM*PRIO_W-1:0] int_prio,
  input  logic [PRIO_W-1:0]         int_thresh,
  input  logic                      claim_req,
  input  logic                      complete_vld,
  input  logic [ID_W-1:0]           complete_id,
  output logic                      int_req,
  output logic                      claim_ack,
  output logic [ID_W-1:0]           claim_id,
  output logic [ID_W-1:0]           active_id,
  output logic                      cmpl_err
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StSvc  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [INT_NUM-1:0]  in_svc_q, in_svc_d;
  logic                win_vld_q;
  logic [ID_W-1:0]     win_id_q;
  logic                claim_ack_q, claim_ack_d;
  logic [ID_W-1:0]     claim_id_q, claim_id_d;
  logic [ID_W-1:0]     active_id_q, active_id_d;
  logic                cmpl_err_q, cmpl_err_d;

  logic [PRIO_W-1:0]   prio_a [INT_NUM];
  logic [INT_NUM-1:0]  elig;
  logic                best_vld;
  logic [ID_W-1:0]     best_id;
  logic [PRIO_W-1:0]   best_prio;
  logic [ID_W-1:0]     cand;

`ifdef PIC_ARB_RR_EN
  localparam int unsigned CW = ID_W + 1;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       cand_w;
`endif

  always_comb begin
    elig = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      prio_a[i] = int_prio[i*PRIO_W +: PRIO_W];
      elig[i]   = int_pend[i] & ~in_svc_q[i] & (prio_a[i] > int_thresh);
    end
    elig[0] = 1'b0;
  end

  // Scan sources in tie-break order; only a strictly higher priority displaces the current best.
  always_comb begin
    best_vld  = 1'b0;
    best_id   = '0;
    best_prio = '0;
    cand      = '0;
`ifdef PIC_ARB_RR_EN
    cand_w    = '0;
`endif
    for (int k = 0; k < INT_NUM - 1; k++) begin
`ifdef PIC_ARB_RR_EN
      cand_w = {1'b0, rr_ptr_q} + CW'(k + 1);
      if (cand_w > CW'(INT_NUM - 1)) cand_w = cand_w - CW'(INT_NUM - 1);
      cand = cand_w[ID_W-1:0];
`else
      cand = ID_W'(k + 1);
`endif
      if (elig[cand] && (!best_vld || (prio_a[cand] > best_prio))) begin
        best_vld  = 1'b1;
        best_id   = cand;
        best_prio = prio_a[cand];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    in_svc_d    = in_svc_q;
    active_id_d = active_id_q;
    claim_ack_d = claim_req;
    claim_id_d  = '0;
    cmpl_err_d  = complete_vld &&
                  !((state_q == StSvc) && (complete_id == active_id_q));
`ifdef PIC_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_vld_q) state_d = StReq;
      end
      StReq: begin
        if (claim_req && win_vld_q) begin
          claim_id_d          = win_id_q;
          in_svc_d[win_id_q]  = 1'b1;
          active_id_d         = win_id_q;
          state_d             = StSvc;
`ifdef PIC_ARB_RR_EN
          rr_ptr_d            = win_id_q;
`endif
        end else if (!win_vld_q) begin
          state_d = StIdle;
        end
      end
      StSvc: begin
        if (complete_vld && (complete_id == active_id_q)) begin
          in_svc_d[active_id_q] = 1'b0;
          active_id_d           = '0;
          state_d               = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pic_clk or posedge pic_rst) begin
    if (pic_rst) begin
      state_q     <= StIdle;
      in_svc_q    <= '0;
      win_vld_q   <= 1'b0;
      win_id_q    <= '0;
      claim_ack_q <= 1'b0;
      claim_id_q  <= '0;
      active_id_q <= '0;
      cmpl_err_q  <= 1'b0;
`ifdef PIC_ARB_RR_EN
      rr_ptr_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      in_svc_q    <= in_svc_d;
      win_vld_q   <= best_vld;
      win_id_q    <= best_id;
      claim_ack_q <= claim_ack_d;
      claim_id_q  <= claim_id_d;
      active_id_q <= active_id_d;
      cmpl_err_q  <= cmpl_err_d;
`ifdef PIC_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign int_req   = (state_q == StReq);
  assign claim_ack = claim_ack_q;
  assign claim_id  = claim_id_q;
  assign active_id = active_id_q;
  assign cmpl_err  = cmpl_err_q;

endmodule
